backtrack_ctrl: RTL and testbench

//  Undo side of the decision/level protocol: on a conflict, clears every assigned variable above the target level.

---
 rtl/sat_pkg.sv | 21 ++
 rtl/backtrack_ctrl_if.sv | 33 +++
 rtl/bkt_scan_group.sv | 32 +++
 rtl/backtrack_ctrl.sv | 150 +++++++++++++++
 tb/tb_backtrack_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared value encodings, level constants and backtrack FSM states
package sat_pkg;

    localparam int WIDTH_LVL_DEF = 16;

    // Per-var value field {implied, val[1:0]}; only val[1:0] encodes the assignment.
    localparam logic [1:0] VAL_FREE  = 2'b00;
    localparam logic [1:0] VAL_FALSE = 2'b01;
    localparam logic [1:0] VAL_TRUE  = 2'b10;

    // Current level reported by decision when no level is open.
    localparam logic [WIDTH_LVL_DEF-1:0] LVL_NONE = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SCAN,
        ST_APPLY
    } bkt_state_e;

endpackage

// File: rtl/backtrack_ctrl_if.sv
// rtl/backtrack_ctrl_if.sv - request/response bundle between state_list and backtrack_ctrl
// Ports (from the slave side):
//   in : bkt_req_i, bkt_tgt_lvl_i, cur_lvl_i, vars_value_i, vars_lvl_i
//   out: busy_o, var_clear_o, apply_bkt_o, bkt_lvl_o, unsat_o, err_o, done_o
interface backtrack_ctrl_if
    import sat_pkg::*;
#(
    parameter int NUM_VARS  = 8,
    parameter int WIDTH_LVL = WIDTH_LVL_DEF
);
    logic                          bkt_req_i;
    logic [WIDTH_LVL-1:0]          bkt_tgt_lvl_i;
    logic [WIDTH_LVL-1:0]          cur_lvl_i;
    logic [NUM_VARS*3-1:0]         vars_value_i;
    logic [NUM_VARS*WIDTH_LVL-1:0] vars_lvl_i;
    logic                          busy_o;
    logic [NUM_VARS-1:0]           var_clear_o;
    logic                          apply_bkt_o;
    logic [WIDTH_LVL-1:0]          bkt_lvl_o;
    logic                          unsat_o;
    logic                          err_o;
    logic                          done_o;

    modport master (
        output bkt_req_i, bkt_tgt_lvl_i, cur_lvl_i, vars_value_i, vars_lvl_i,
        input  busy_o, var_clear_o, apply_bkt_o, bkt_lvl_o, unsat_o, err_o, done_o
    );

    modport slave (
        input  bkt_req_i, bkt_tgt_lvl_i, cur_lvl_i, vars_value_i, vars_lvl_i,
        output busy_o, var_clear_o, apply_bkt_o, bkt_lvl_o, unsat_o, err_o, done_o
    );
endinterface

// File: rtl/bkt_scan_group.sv
// rtl/bkt_scan_group.sv - combinational compare of one var group against target level
// Ports:
//   val_i     : VARS_PER_CYC x {implied, val[1:0]}
//   lvl_i     : VARS_PER_CYC x WIDTH_LVL assignment levels
//   tgt_lvl_i : target level L
//   mask_o    : bit set where var is assigned and its level is above L
module bkt_scan_group
    import sat_pkg::*;
#(
    parameter int VARS_PER_CYC = 4,
    parameter int WIDTH_LVL    = WIDTH_LVL_DEF
) (
    input  logic [VARS_PER_CYC*3-1:0]         val_i,
    input  logic [VARS_PER_CYC*WIDTH_LVL-1:0] lvl_i,
    input  logic [WIDTH_LVL-1:0]              tgt_lvl_i,
    output logic [VARS_PER_CYC-1:0]           mask_o
);

    // The implied flag does not affect clearing; collected here only to mark it consumed.
    logic [VARS_PER_CYC-1:0] unused_implied;

    always_comb begin
        mask_o         = '0;
        unused_implied = '0;
        for (int i = 0; i < VARS_PER_CYC; i++) begin
            unused_implied[i] = val_i[i*3+2];
            mask_o[i] = (val_i[i*3 +: 2] != VAL_FREE) &&
                        (lvl_i[i*WIDTH_LVL +: WIDTH_LVL] > tgt_lvl_i);
        end
    end

endmodule

// File: rtl/backtrack_ctrl.sv
// rtl/backtrack_ctrl.sv - conflict backtrack: clears vars above target level, rewinds decision
// Ports:
//   clk, rst : clock, synchronous active-low reset
//   bus      : backtrack_ctrl_if.slave (request, var vectors, clear mask, apply/done pulses)
module backtrack_ctrl
    import sat_pkg::*;
#(
    parameter int NUM_VARS     = 8,
    parameter int WIDTH_LVL    = WIDTH_LVL_DEF,
    parameter int VARS_PER_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    backtrack_ctrl_if.slave   bus
);

    localparam int NGRP  = NUM_VARS / VARS_PER_CYC;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    bkt_state_e                state_q;
    logic [GRP_W-1:0]          grp_q;
    logic [NUM_VARS-1:0]       acc_q;
    logic [NUM_VARS-1:0]       acc_d;
    logic [WIDTH_LVL-1:0]      tgt_q;
    logic                      busy_q;
    logic [NUM_VARS-1:0]       var_clear_q;
    logic                      apply_q;
    logic [WIDTH_LVL-1:0]      bkt_lvl_q;
    logic                      unsat_q;
    logic                      err_q;
    logic                      done_q;

    logic [VARS_PER_CYC*3-1:0]         grp_val;
    logic [VARS_PER_CYC*WIDTH_LVL-1:0] grp_lvl;
    logic [VARS_PER_CYC-1:0]           grp_mask;
    logic                              last_grp;

    // Constant-index mux keeps the group select free of variable part-selects.
    always_comb begin
        grp_val = '0;
        grp_lvl = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (grp_q == GRP_W'(g)) begin
                grp_val = bus.vars_value_i[g*VARS_PER_CYC*3 +: VARS_PER_CYC*3];
                grp_lvl = bus.vars_lvl_i[g*VARS_PER_CYC*WIDTH_LVL +: VARS_PER_CYC*WIDTH_LVL];
            end
        end
    end

    bkt_scan_group #(
        .VARS_PER_CYC (VARS_PER_CYC),
        .WIDTH_LVL    (WIDTH_LVL)
    ) u_scan (
        .val_i     (grp_val),
        .lvl_i     (grp_lvl),
        .tgt_lvl_i (tgt_q),
        .mask_o    (grp_mask)
    );

    always_comb begin
        acc_d = acc_q;
        for (int g = 0; g < NGRP; g++) begin
            if (grp_q == GRP_W'(g)) begin
                acc_d[g*VARS_PER_CYC +: VARS_PER_CYC] = grp_mask;
            end
        end
    end

    assign last_grp = (grp_q == GRP_W'(NGRP - 1));

    // Outputs are registered: the verdict for CHECK is computed on the accepting
    // edge so unsat/err appear during the CHECK cycle, and the final mask is
    // loaded on the last SCAN edge so the clear pulse appears during APPLY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grp_q       <= '0;
            acc_q       <= '0;
            tgt_q       <= '0;
            busy_q      <= 1'b0;
            var_clear_q <= '0;
            apply_q     <= 1'b0;
            bkt_lvl_q   <= '0;
            unsat_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            var_clear_q <= '0;
            apply_q     <= 1'b0;
            bkt_lvl_q   <= '0;
            unsat_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.bkt_req_i) begin
                        tgt_q   <= bus.bkt_tgt_lvl_i;
                        grp_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CHECK;
                        // All-ones means no level is open, which is the root as well.
                        if (bus.cur_lvl_i == '0 || bus.cur_lvl_i == {WIDTH_LVL{1'b1}}) begin
                            unsat_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (bus.bkt_tgt_lvl_i >= bus.cur_lvl_i) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (done_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    acc_q <= acc_d;
                    grp_q <= grp_q + GRP_W'(1);
                    if (last_grp) begin
                        var_clear_q <= acc_d;
                        apply_q     <= 1'b1;
                        bkt_lvl_q   <= tgt_q + WIDTH_LVL'(1);
                        done_q      <= 1'b1;
                        state_q     <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    busy_q  <= 1'b0;
                    acc_q   <= '0;
                    grp_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.var_clear_o = var_clear_q;
    assign bus.apply_bkt_o = apply_q;
    assign bus.bkt_lvl_o   = bkt_lvl_q;
    assign bus.unsat_o     = unsat_q;
    assign bus.err_o       = err_q;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_backtrack_ctrl.sv
// tb/tb_backtrack_ctrl.sv - scoreboard bench for backtrack_ctrl
module tb_backtrack_ctrl;
    import sat_pkg::*;

    localparam int NV  = 8;
    localparam int WL  = 16;
    localparam int VPC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    backtrack_ctrl_if #(.NUM_VARS(NV), .WIDTH_LVL(WL)) bus ();

    backtrack_ctrl #(
        .NUM_VARS     (NV),
        .WIDTH_LVL    (WL),
        .VARS_PER_CYC (VPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NV-1:0] clear;
        logic          apply;
        logic [WL-1:0] lvl;
        logic          unsat;
        logic          err;
        int            due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   mon_en      = 1'b0;

    int         lv_tbl  [NV];
    logic [1:0] val_tbl [NV];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NV-1:0] model_mask(input logic [NV*3-1:0] v,
                                                 input logic [NV*WL-1:0] l,
                                                 input logic [WL-1:0] tgt);
        logic [NV-1:0] m;
        m = '0;
        for (int i = 0; i < NV; i++)
            m[i] = (v[i*3 +: 2] != VAL_FREE) && (l[i*WL +: WL] > tgt);
        return m;
    endfunction

    task automatic load_vars();
        for (int i = 0; i < NV; i++) begin
            bus.vars_value_i[i*3 +: 3] = {i[0], val_tbl[i]};
            bus.vars_lvl_i[i*WL +: WL] = WL'(lv_tbl[i]);
        end
    endtask

    // Drives the request for the next posedge and queues the expected response.
    task automatic drive_req(input logic [WL-1:0] tgt, input logic [WL-1:0] cur, input bit accept);
        exp_t x;
        bus.bkt_req_i     = 1'b1;
        bus.bkt_tgt_lvl_i = tgt;
        bus.cur_lvl_i     = cur;
        if (accept) begin
            x.clear = '0; x.apply = 1'b0; x.lvl = '0; x.unsat = 1'b0; x.err = 1'b0;
            if (cur == '0 || cur == {WL{1'b1}}) begin
                x.unsat = 1'b1; x.due = cyc + 1;
            end else if (tgt >= cur) begin
                x.err = 1'b1; x.due = cyc + 1;
            end else begin
                x.clear = model_mask(bus.vars_value_i, bus.vars_lvl_i, tgt);
                x.apply = 1'b1;
                x.lvl   = tgt + WL'(1);
                x.due   = cyc + 2 + NV / VPC;
            end
            sb.push_back(x);
        end
    endtask

    task automatic issue(input logic [WL-1:0] tgt, input logic [WL-1:0] cur);
        @(negedge clk);
        drive_req(tgt, cur, 1'b1);
        @(negedge clk);
        bus.bkt_req_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && (sb.size() != 0 || bus.busy_o); i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_timeout", {31'b0, (sb.size() != 0) || bus.busy_o}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  {31'b0, bus.busy_o},      32'd0);
        check({tag, "_done"},  {31'b0, bus.done_o},      32'd0);
        check({tag, "_clear"}, {24'b0, bus.var_clear_o}, 32'd0);
        check({tag, "_apply"}, {31'b0, bus.apply_bkt_o}, 32'd0);
        check({tag, "_lvl"},   {16'b0, bus.bkt_lvl_o},   32'd0);
        check({tag, "_unsat"}, {31'b0, bus.unsat_o},     32'd0);
        check({tag, "_err"},   {31'b0, bus.err_o},       32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.done_o) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("var_clear", {24'b0, bus.var_clear_o}, {24'b0, e.clear});
                    check("apply_bkt", {31'b0, bus.apply_bkt_o}, {31'b0, e.apply});
                    check("bkt_lvl",   {16'b0, bus.bkt_lvl_o},   {16'b0, e.lvl});
                    check("unsat",     {31'b0, bus.unsat_o},     {31'b0, e.unsat});
                    check("err",       {31'b0, bus.err_o},       {31'b0, e.err});
                    check("latency",   cyc,                      e.due);
                    check("busy_at_done", {31'b0, bus.busy_o},   32'd1);
                end
            end else begin
                check("quiet_outputs",
                      {31'b0, (|bus.var_clear_o) | bus.apply_bkt_o | (|bus.bkt_lvl_o) |
                              bus.unsat_o | bus.err_o}, 32'd0);
            end
        end
    end

    initial begin
        int t0;
        bus.bkt_req_i     = 1'b1;
        bus.bkt_tgt_lvl_i = WL'(1);
        bus.cur_lvl_i     = WL'(3);
        lv_tbl  = '{0, 1, 2, 3, 1, 2, 0, 3};
        val_tbl = '{VAL_TRUE, VAL_FALSE, VAL_TRUE, VAL_TRUE, VAL_FALSE, VAL_TRUE, VAL_FALSE, VAL_TRUE};
        load_vars();

        // Reset held with a request pending.
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        rst = 1'b1;
        bus.bkt_req_i = 1'b0;
        mon_en = 1'b1;

        // Legal backtrack, all vars assigned.
        issue(WL'(1), WL'(3));
        wait_idle();

        // Var5 free must not be cleared.
        val_tbl[5] = VAL_FREE;
        load_vars();
        issue(WL'(1), WL'(3));
        wait_idle();

        // L = cur-1 and L = 0 boundaries; then empty mask still applies.
        issue(WL'(2), WL'(3));
        wait_idle();
        issue(WL'(0), WL'(3));
        wait_idle();
        issue(WL'(5), WL'(9));
        wait_idle();

        // Root conflicts and illegal requests.
        issue(WL'(5), WL'(0));
        wait_idle();
        issue(WL'(0), {WL{1'b1}});
        wait_idle();
        issue(WL'(2), WL'(2));
        wait_idle();
        issue(WL'(7), WL'(2));
        wait_idle();

        // Second request while busy is dropped.
        @(negedge clk);
        drive_req(WL'(1), WL'(3), 1'b1);
        @(negedge clk);
        bus.bkt_req_i = 1'b0;
        @(negedge clk);
        drive_req(WL'(0), WL'(3), 1'b0);
        @(negedge clk);
        bus.bkt_req_i = 1'b0;
        wait_idle();

        // Request coincident with done is dropped; one cycle later it is taken.
        @(negedge clk);
        t0 = cyc;
        drive_req(WL'(1), WL'(3), 1'b1);
        @(negedge clk);
        bus.bkt_req_i = 1'b0;
        while (cyc < t0 + 4) @(negedge clk);
        drive_req(WL'(0), WL'(3), 1'b0);
        @(negedge clk);
        drive_req(WL'(0), WL'(3), 1'b1);
        @(negedge clk);
        bus.bkt_req_i = 1'b0;
        wait_idle();
        check("busy_after_idle", {31'b0, bus.busy_o}, 32'd0);

        // Reset in the middle of SCAN: no clear pulse may ever appear.
        @(negedge clk);
        drive_req(WL'(0), WL'(3), 1'b0);
        @(negedge clk);
        bus.bkt_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_after_reset", {31'b0, bus.busy_o}, 32'd0);

        // Normal operation resumes after the aborted request.
        issue(WL'(1), WL'(3));
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
